// File: rtl/acc_interconnect_level.sv
// One level of the accelerator interconnect: routes offloaded requests to local
// accelerators or the next level, and merges responses round-robin onto one upstream channel.

module acc_interconnect_level_chk #(
  parameter int unsigned NumAcc = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  input logic [NumAcc-1:0] acc_q_valid,
  input logic [NumAcc+1:0] in_ready
);

  acc_q_valid_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(acc_q_valid));
  in_ready_onehot0:    assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(in_ready));

endmodule

module acc_interconnect_level #(
  parameter int unsigned NumAcc        = 4,
  parameter int unsigned HierLevel     = 0,
  parameter int unsigned HierAddrWidth = 2,
  parameter int unsigned AccAddrWidth  = 2,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned IdWidth       = 5,
  parameter int unsigned PldWidth      = 3*DataWidth+32+IdWidth
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [HierAddrWidth+AccAddrWidth-1:0] q_addr_i,
  input  logic [PldWidth-1:0]                   q_pld_i,
  input  logic                                  q_valid_i,
  output logic                                  q_ready_o,
  output logic [PldWidth-1:0]                   acc_q_pld_o,
  output logic [NumAcc-1:0]                     acc_q_valid_o,
  input  logic [NumAcc-1:0]                     acc_q_ready_i,
  output logic [HierAddrWidth+AccAddrWidth-1:0] nxt_q_addr_o,
  output logic [PldWidth-1:0]                   nxt_q_pld_o,
  output logic                                  nxt_q_valid_o,
  input  logic                                  nxt_q_ready_i,
  input  logic [NumAcc*DataWidth-1:0]           acc_p_data_i,
  input  logic [NumAcc*IdWidth-1:0]             acc_p_id_i,
  input  logic [NumAcc-1:0]                     acc_p_error_i,
  input  logic [NumAcc-1:0]                     acc_p_valid_i,
  output logic [NumAcc-1:0]                     acc_p_ready_o,
  input  logic [DataWidth-1:0]                  nxt_p_data_i,
  input  logic [IdWidth-1:0]                    nxt_p_id_i,
  input  logic                                  nxt_p_error_i,
  input  logic                                  nxt_p_valid_i,
  output logic                                  nxt_p_ready_o,
  output logic [DataWidth-1:0]                  p_data_o,
  output logic [IdWidth-1:0]                    p_id_o,
  output logic                                  p_error_o,
  output logic                                  p_valid_o,
  input  logic                                  p_ready_i
);

  localparam int unsigned AddrWidth = HierAddrWidth + AccAddrWidth;
  localparam int unsigned NumIn     = NumAcc + 2;
  localparam int unsigned PtrWidth  = $clog2(NumIn);

  logic [HierAddrWidth-1:0] hier_s;
  logic [AccAddrWidth-1:0]  acc_idx_s;
  logic                     hier_hit_s;
  logic                     acc_legal_s;
  logic [NumAcc-1:0]        acc_oh_s;
  logic                     req_full_s;
  logic                     req_drain_s;
  logic                     q_hs_s;

  logic [NumAcc-1:0]        req_acc_vld_r;
  logic                     req_nxt_vld_r;
  logic                     req_ill_r;
  logic [AddrWidth-1:0]     req_addr_r;
  logic [PldWidth-1:0]      req_pld_r;

  logic [NumIn-1:0]         vld_s;
  logic                     gnt_found_s;
  logic [PtrWidth-1:0]      gnt_idx_s;
  logic                     p_load_s;
  logic                     xfer_s;
  logic                     err_take_s;
  logic [DataWidth-1:0]     gnt_data_s;
  logic [IdWidth-1:0]       gnt_id_s;
  logic                     gnt_err_s;
  logic [PtrWidth-1:0]      ptr_r;
  logic [PtrWidth-1:0]      ptr_nxt_s;

  logic                     p_full_r;
  logic [DataWidth-1:0]     p_data_r;
  logic [IdWidth-1:0]       p_id_r;
  logic                     p_err_r;

  assign hier_s      = q_addr_i[AddrWidth-1 -: HierAddrWidth];
  assign acc_idx_s   = q_addr_i[AccAddrWidth-1:0];
  assign hier_hit_s  = (hier_s == HierAddrWidth'(HierLevel));
  assign acc_legal_s = ({1'b0, acc_idx_s} < (AccAddrWidth+1)'(NumAcc));

  // Onehot target decode for a request addressed to this level
  always_comb begin
    acc_oh_s = '0;
    for (int k = 0; k < NumAcc; k++) begin
      acc_oh_s[k] = hier_hit_s && acc_legal_s && (acc_idx_s == AccAddrWidth'(k));
    end
  end

  assign req_full_s  = (|req_acc_vld_r) | req_nxt_vld_r | req_ill_r;
  assign req_drain_s = (|(req_acc_vld_r & acc_q_ready_i)) | (req_nxt_vld_r & nxt_q_ready_i)
                     | (req_ill_r & err_take_s);
  assign q_ready_o   = !req_full_s || req_drain_s;
  assign q_hs_s      = q_valid_i && q_ready_o;

  // Request register: target valids are decoded once at acceptance
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_acc_vld_r <= '0;
      req_nxt_vld_r <= 1'b0;
      req_ill_r     <= 1'b0;
      req_addr_r    <= '0;
      req_pld_r     <= '0;
    end else if (q_hs_s) begin
      req_acc_vld_r <= acc_oh_s;
      req_nxt_vld_r <= !hier_hit_s;
      req_ill_r     <= hier_hit_s && !acc_legal_s;
      req_addr_r    <= q_addr_i;
      req_pld_r     <= q_pld_i;
    end else if (req_drain_s) begin
      req_acc_vld_r <= '0;
      req_nxt_vld_r <= 1'b0;
      req_ill_r     <= 1'b0;
    end
  end

  assign acc_q_pld_o   = req_pld_r;
  assign acc_q_valid_o = req_acc_vld_r;
  assign nxt_q_addr_o  = req_addr_r;
  assign nxt_q_pld_o   = req_pld_r;
  assign nxt_q_valid_o = req_nxt_vld_r;

  // Input NumAcc+1 is the locally generated error for an illegal index
  assign vld_s = {req_ill_r, nxt_p_valid_i, acc_p_valid_i};

  // Round-robin search starting at the pointer, wrapping over all inputs
  always_comb begin : arb_search
    int unsigned         cand;
    logic [PtrWidth-1:0] cand_idx;
    logic                hit;
    cand        = 32'd0;
    cand_idx    = '0;
    hit         = 1'b0;
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      cand        = (32'(ptr_r) + i) % NumIn;
      cand_idx    = PtrWidth'(cand);
      hit         = vld_s[cand_idx] && !gnt_found_s;
      gnt_found_s = gnt_found_s | hit;
      gnt_idx_s   = hit ? cand_idx : gnt_idx_s;
    end
  end

  assign p_load_s   = !p_full_r || p_ready_i;
  assign xfer_s     = gnt_found_s && p_load_s;
  assign err_take_s = xfer_s && (gnt_idx_s == PtrWidth'(NumAcc+1));
  assign ptr_nxt_s  = (gnt_idx_s == PtrWidth'(NumIn-1)) ? PtrWidth'(0) : gnt_idx_s + PtrWidth'(1);

  // Ready fan-out: only the granted input sees a transfer
  always_comb begin
    acc_p_ready_o = '0;
    for (int k = 0; k < NumAcc; k++) begin
      acc_p_ready_o[k] = xfer_s && (gnt_idx_s == PtrWidth'(k));
    end
    nxt_p_ready_o = xfer_s && (gnt_idx_s == PtrWidth'(NumAcc));
  end

  // Response mux, defaulting to the error response built from the held request id
  always_comb begin
    gnt_data_s = '0;
    gnt_id_s   = req_pld_r[IdWidth-1:0];
    gnt_err_s  = 1'b1;
    for (int k = 0; k < NumAcc; k++) begin
      if (gnt_idx_s == PtrWidth'(k)) begin
        gnt_data_s = acc_p_data_i[k*DataWidth +: DataWidth];
        gnt_id_s   = acc_p_id_i[k*IdWidth +: IdWidth];
        gnt_err_s  = acc_p_error_i[k];
      end else begin
        gnt_data_s = gnt_data_s;
      end
    end
    if (gnt_idx_s == PtrWidth'(NumAcc)) begin
      gnt_data_s = nxt_p_data_i;
      gnt_id_s   = nxt_p_id_i;
      gnt_err_s  = nxt_p_error_i;
    end else begin
      gnt_data_s = gnt_data_s;
    end
  end

  // Response register and round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p_full_r <= 1'b0;
      p_data_r <= '0;
      p_id_r   <= '0;
      p_err_r  <= 1'b0;
      ptr_r    <= '0;
    end else if (xfer_s) begin
      p_full_r <= 1'b1;
      p_data_r <= gnt_data_s;
      p_id_r   <= gnt_id_s;
      p_err_r  <= gnt_err_s;
      ptr_r    <= ptr_nxt_s;
    end else if (p_ready_i) begin
      p_full_r <= 1'b0;
    end
  end

  assign p_valid_o = p_full_r;
  assign p_data_o  = p_data_r;
  assign p_id_o    = p_id_r;
  assign p_error_o = p_err_r;

  acc_interconnect_level_chk #(
    .NumAcc (NumAcc)
  ) u_chk (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .acc_q_valid (acc_q_valid_o),
    .in_ready    ({err_take_s, nxt_p_ready_o, acc_p_ready_o})
  );

endmodule
